lane_pair_checker: RTL and testbench
====================================

Name: lane_pair_checker

Overview:
- Downstream stage of the dual-lane "+5" datapath. It consumes the two registered 32-bit lane results each cycle through a valid/ready handshake.
- Each lane pair is buffered in a small FIFO and compared lane A against lane B. A tagged result stream goes to the next consumer.
- Mismatches are counted. An FSM halts intake after a run of consecutive mismatches, so lane divergence is caught in simulation and by formal assertions.

Parameters:
- WIDTH, 32, lane data width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 8, width of the mismatch counter.
- THRESH, 3, number of consecutive mismatching pops that forces HALT; valid range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state updates on its posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  lane pair offered.
- in_a  in  WIDTH  lane A result.
- in_b  in  WIDTH  lane B result.
- in_ready  out  1  checker can accept a pair this cycle.
- out_valid  out  1  head entry available.
- out_data  out  WIDTH  lane A value of the head entry.
- out_match  out  1  1 when the head entry had in_a == in_b.
- out_ready  in  1  downstream accepts the head entry.
- err_clr  in  1  single-cycle pulse: clear the counter and the error state.
- err  out  1  sticky; high in FAULT or HALT.
- halted  out  1  high in HALT.
- mismatch_cnt  out  CNT_W  saturating count of popped mismatching entries.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty and pointers 0.
  - mismatch_cnt 0, consecutive-mismatch counter 0, state RUN.
  - out_valid 0, err 0, halted 0, in_ready 1.
  - Reset applied mid-operation discards all buffered entries immediately.
- Push: occurs when in_valid && in_ready.
  - The entry stores {in_a, (in_a == in_b)}; the full WIDTH-bit equality is computed at push time.
- in_ready:
  - in_ready = (occupancy < DEPTH) && (state != HALT).
  - It never depends on out_ready; a full FIFO refuses a push even in a cycle where a pop occurs.
- Pop: occurs when out_valid && out_ready. out_valid = (occupancy != 0).
  - out_data and out_match are the head entry and are held stable while out_valid && !out_ready.
- Latency and ordering:
  - No bypass: a pair pushed into an empty FIFO is presented on out_valid the next cycle.
  - Entries pop in push order.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is a separate (log2(DEPTH)+1)-bit counter.
- Popping a mismatching entry (out_match == 0):
  - mismatch_cnt increments, saturating at 2^CNT_W-1.
  - The consecutive counter increments.
  - Popping a matching entry resets the consecutive counter to 0.
- FSM states: RUN, FAULT, HALT.
  - RUN -> FAULT on a mismatching pop, or directly RUN -> HALT if that pop brings the consecutive count to THRESH.
  - FAULT -> HALT when the consecutive count reaches THRESH.
  - FAULT and HALT -> RUN on err_clr.
  - HALT blocks pushes only; buffered entries keep draining, so out_valid and the pop rules are unaffected.
- err_clr:
  - Sets state to RUN and clears mismatch_cnt and the consecutive counter.
  - If err_clr coincides with a mismatching pop, the pop wins: mismatch_cnt = 1, consecutive = 1, and the state becomes FAULT (HALT if THRESH == 1).
  - err_clr in RUN with no mismatching pop only clears the counters.
- Outputs: err = (state != RUN); halted = (state == HALT). Both are decoded from registered state, with no combinational path from inputs.
- Required assertions (written in the block):
  - Occupancy never exceeds DEPTH.
  - No push while halted.
  - out_data is stable while out_valid && !out_ready.
  - err is high whenever halted is high.

Test Plan:
1. Reset, then push (5, 5) with out_ready = 1 -> out_valid the next cycle with out_data = 5, out_match = 1; err = 0; mismatch_cnt = 0.
2. out_ready = 0; push pairs (10,10), (11,11), (12,12), (13,13) -> in_ready drops after the 4th push, and a 5th offer with out_ready toggled to 1 in that cycle is still refused. Then 10, 11, 12, 13 drain in order.
3. Push (7, 8) with out_ready = 1 -> out_match = 0 on pop, mismatch_cnt = 1, err = 1, halted = 0. Push (9, 9) -> consecutive counter cleared and the state stays FAULT.
4. Push (1,2), (3,4), (5,6) back-to-back with THRESH = 3 -> halted = 1 after the 3rd pop and in_ready = 0. Pulse err_clr -> state RUN, mismatch_cnt = 0, in_ready = 1.
5. Pulse err_clr in the same cycle that a (20, 21) entry pops -> mismatch_cnt = 1, err = 1.
6. Fill 2 entries, then assert rst_n low mid-stream -> out_valid = 0, in_ready = 1, and err = 0 in the same cycle. Separately, force 260 mismatches with CNT_W = 8 -> mismatch_cnt saturates at 255.

Source files
------------

// File: rtl/lane_pair_checker.sv
// lane_pair_checker
// Downstream stage of the dual-lane "+5" datapath. Each accepted lane pair
// is stored in a small FIFO as {lane A value, lane A == lane B}. The head
// entry is offered to the next consumer. Mismatching entries are counted
// when they pop, and an FSM halts intake after THRESH consecutive
// mismatching pops.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   lane pair intake handshake
//   in_a, in_b          lane A / lane B results
//   out_valid/out_ready head-entry handshake
//   out_data            lane A value of the head entry
//   out_match           head entry had in_a == in_b
//   err_clr             pulse: clear counters and return to RUN
//   err                 high in FAULT or HALT
//   halted              high in HALT
//   mismatch_cnt        saturating count of popped mismatching entries
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid never waits on ready, ready never depends on the
// partner's valid, and payload is held stable while valid && !ready.
// in_ready is registered-state only (occupancy and FSM state), so a full
// FIFO refuses a push even when a pop happens in the same cycle.
module lane_pair_checker #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_match,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             err,
  output logic             halted,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FAULT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      THRESH_C = (AW+1)'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_match;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  // Consecutive-mismatch run length; saturates at THRESH so it never wraps
  // while a halted FIFO keeps draining mismatches.
  logic [AW:0]      cons;
  logic [AW:0]      cons_nxt;

  logic push;
  logic pop;
  logic pop_mis;

  assign in_ready  = (occ != DEPTH_C) && (state != ST_HALT);
  assign out_valid = (occ != '0);
  assign out_data  = mem_data[rd_ptr];
  assign out_match = mem_match[rd_ptr];

  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign pop_mis = pop && !out_match;

  assign err          = (state != ST_RUN);
  assign halted       = (state == ST_HALT);
  assign mismatch_cnt = cnt;

  // Storage needs no reset: reset empties the FIFO through the pointers
  // and occupancy, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= in_a;
      mem_match[wr_ptr] <= (in_a == in_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // A mismatching pop takes priority over err_clr: the clear happens first
  // and the pop is then counted as the first of a new run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cons_nxt  = cons;
    if (pop_mis) begin
      if (err_clr) begin
        cnt_nxt  = CNT_W'(1);
        cons_nxt = (AW+1)'(1);
      end else begin
        cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        cons_nxt = (cons >= THRESH_C) ? THRESH_C : cons + (AW+1)'(1);
      end
      if (cons_nxt == THRESH_C) begin
        state_nxt = ST_HALT;
      end else if ((state == ST_HALT) && !err_clr) begin
        state_nxt = ST_HALT;
      end else begin
        state_nxt = ST_FAULT;
      end
    end else begin
      if (pop) cons_nxt = '0;
      if (err_clr) begin
        cnt_nxt   = '0;
        cons_nxt  = '0;
        state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
      cons  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cons  <= cons_nxt;
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= DEPTH_C);

  a_no_push_halted: assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> !push);

  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_match)));

  a_err_when_halted: assert property (@(posedge clk) disable iff (!rst_n)
    halted |-> err);

endmodule

// File: tb/tb_lane_pair_checker.sv
module tb_lane_pair_checker;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int THRESH = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_match;
  logic             out_ready;
  logic             err_clr;
  logic             err;
  logic             halted;
  logic [CNT_W-1:0] mismatch_cnt;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  lane_pair_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_match(out_match),
    .out_ready(out_ready), .err_clr(err_clr),
    .err(err), .halted(halted), .mismatch_cnt(mismatch_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        iv;
    logic [31:0] a;
    logic [31:0] b;
    logic        ordy;
    logic        clr;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    logic        e_match;
    logic        e_err;
    logic        e_halt;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iv, input logic [31:0] a, input logic [31:0] b,
    input logic ordy, input logic clr,
    input logic ir, input logic ov, input logic [31:0] d, input logic m,
    input logic e, input logic h, input logic [7:0] c);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.ordy = ordy; v.clr = clr;
    v.e_ir = ir; v.e_ov = ov; v.e_data = d; v.e_match = m;
    v.e_err = e; v.e_halt = h; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic clr);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    err_clr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle against the scoreboard: head data must match the oldest
  // expected entry, a pop consumes it, an accepted push appends to it.
  task automatic cyc_sb(input string tag, input logic iv, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy, input logic exp_ready);
    drive(iv, a, b, ordy, 1'b0);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk({tag, ".out_data"}, out_data, exp_q[0]);
      if (ordy) void'(exp_q.pop_front());
    end
    if (iv && exp_ready) exp_q.push_back(a);
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    chk("rst.cnt", 32'(mismatch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //              iv a   b   ordy clr | ir ov data m  err h cnt
    vecs.push_back(mk(1, 5,  5,  1, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 1, 5,  1, 0, 0, 0));
    vecs.push_back(mk(1, 10, 10, 0, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 11, 11, 0, 0,   1, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk(1, 12, 12, 0, 0,   1, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk(1, 13, 13, 0, 0,   1, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk(1, 14, 14, 1, 0,   0, 1, 10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 1, 11, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 1, 12, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 1, 13, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 7,  8,  1, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 9,  9,  1, 0,   1, 1, 7,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 1, 9,  1, 1, 0, 1));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk(1, 1,  2,  1, 0,   1, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk(1, 3,  4,  1, 0,   1, 1, 1,  0, 1, 0, 1));
    vecs.push_back(mk(1, 5,  6,  1, 0,   1, 1, 3,  0, 1, 0, 2));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 1, 5,  0, 1, 0, 3));
    vecs.push_back(mk(1, 99, 99, 1, 0,   0, 0, 0,  0, 1, 1, 4));
    vecs.push_back(mk(0, 0,  0,  1, 1,   0, 0, 0,  0, 1, 1, 4));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(1, 20, 21, 0, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 1,   1, 1, 20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  0,  1, 0,   1, 0, 0,  0, 1, 0, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ordy, vecs[i].clr);
      #1;
      chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("row%0d.out_data", i), out_data, vecs[i].e_data);
        chk($sformatf("row%0d.out_match", i), 32'(out_match), 32'(vecs[i].e_match));
      end
      chk($sformatf("row%0d.err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("row%0d.halted", i), 32'(halted), 32'(vecs[i].e_halt));
      chk($sformatf("row%0d.cnt", i), 32'(mismatch_cnt), 32'(vecs[i].e_cnt));
      tick();
    end

    // Reset mid-stream: two buffered entries and a FAULT state vanish
    // as soon as rst_n falls, without waiting for a clock edge.
    drive(1'b1, 32'd30, 32'd30, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'd31, 32'd32, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("mid.pre_out_valid", 32'(out_valid), 32'd1);
    chk("mid.pre_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    chk("mid.err", 32'(err), 32'd0);
    chk("mid.halted", 32'(halted), 32'd0);
    chk("mid.cnt", 32'(mismatch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // HALT blocks intake but the buffered entries keep draining.
    exp_q.delete();
    cyc_sb("halt.fill0", 1'b1, 32'd1, 32'd2, 1'b0, 1'b1);
    cyc_sb("halt.fill1", 1'b1, 32'd3, 32'd4, 1'b0, 1'b1);
    cyc_sb("halt.fill2", 1'b1, 32'd5, 32'd6, 1'b0, 1'b1);
    cyc_sb("halt.fill3", 1'b1, 32'd7, 32'd8, 1'b0, 1'b1);
    cyc_sb("halt.pop0", 1'b0, '0, '0, 1'b1, 1'b0);
    cyc_sb("halt.pop1", 1'b0, '0, '0, 1'b1, 1'b1);
    cyc_sb("halt.pop2", 1'b0, '0, '0, 1'b1, 1'b1);
    #1;
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.err", 32'(err), 32'd1);
    chk("halt.cnt3", 32'(mismatch_cnt), 32'd3);
    cyc_sb("halt.pop3", 1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    chk("halt.still_halted", 32'(halted), 32'd1);
    chk("halt.cnt4", 32'(mismatch_cnt), 32'd4);
    chk("halt.drained", 32'(out_valid), 32'd0);
    chk("halt.in_ready", 32'(in_ready), 32'd0);

    // Saturation: alternate mismatch/match so the run never reaches
    // THRESH; 254 mismatches first, then 6 more past the top.
    pulse_reset();
    for (int i = 0; i < 508; i++) begin
      cyc_sb("sat1", 1'b1, 32'(i), (i % 2 == 0) ? 32'(i + 1) : 32'(i), 1'b1, 1'b1);
    end
    cyc_sb("sat1.drain", 1'b0, '0, '0, 1'b1, 1'b1);
    #1;
    chk("sat.cnt254", 32'(mismatch_cnt), 32'd254);
    chk("sat.err", 32'(err), 32'd1);
    chk("sat.halted", 32'(halted), 32'd0);
    for (int i = 508; i < 520; i++) begin
      cyc_sb("sat2", 1'b1, 32'(i), (i % 2 == 0) ? 32'(i + 1) : 32'(i), 1'b1, 1'b1);
    end
    cyc_sb("sat2.drain", 1'b0, '0, '0, 1'b1, 1'b1);
    #1;
    chk("sat.cnt255", 32'(mismatch_cnt), 32'd255);
    chk("sat.halted_end", 32'(halted), 32'd0);
    chk("sat.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
